// File: rtl/map_sel_ctrl.sv
// Mapper index swap sequencer: waits for a quiet CPU bus, blanks and resets the mappers, then swaps the index.
// Optional MAP_SEL_TOUT_EN forces the swap after a quiet-window timeout and raises a sticky err.
module map_sel_ctrl #(
  parameter int IDX_W    = 8,
  parameter int RST_IDX  = 0,
  parameter int IDLE_CYC = 4,
  parameter int HOLD_CYC = 16,
  parameter int TOUT_CYC = 4096
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cpu_m2,
  input  logic             req,
  input  logic [IDX_W-1:0] req_idx,
  output logic [IDX_W-1:0] map_idx,
  output logic             map_rst,
  output logic             bus_blank,
  output logic             busy,
  output logic             ack,
  output logic             err
);

  localparam int CNT_MAX = (HOLD_CYC > IDLE_CYC) ? HOLD_CYC : IDLE_CYC;
  localparam int HW      = $clog2(CNT_MAX) + 1;
  localparam int QW      = $clog2(IDLE_CYC) + 1;

  localparam logic [HW-1:0]    HOLD_TC    = HW'(HOLD_CYC - 1);
  localparam logic [HW-1:0]    REL_TC     = HW'(IDLE_CYC - 1);
  localparam logic [QW-1:0]    QUIET_FULL = QW'(IDLE_CYC);
  localparam logic [IDX_W-1:0] RST_VAL    = IDX_W'(RST_IDX);

  typedef enum logic [2:0] {INIT, IDLE, QUIET, BLANK, REL} state_t;

  state_t           state;
  state_t           next_state;
  logic             m2_s1;
  logic             m2_s2;
  logic             m2_d;
  logic             m2_rise;
  logic [QW-1:0]    quiet_cnt;
  logic [HW-1:0]    hold_cnt;
  logic [IDX_W-1:0] pend_idx;
  logic             from_init;
  logic             latch_req;
  logic             load_idx;
  logic             exit_rel;
  logic             tout_hit;

  // cpu_m2 is asynchronous; m2_d keeps one extra stage for edge detection.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m2_s1 <= 1'b0;
      m2_s2 <= 1'b0;
      m2_d  <= 1'b0;
    end else begin
      m2_s1 <= cpu_m2;
      m2_s2 <= m2_s1;
      m2_d  <= m2_s2;
    end
  end

  assign m2_rise = m2_s2 & ~m2_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      quiet_cnt <= '0;
    end else if (m2_s2) begin
      quiet_cnt <= '0;
    end else if (quiet_cnt != QUIET_FULL) begin
      quiet_cnt <= quiet_cnt + QW'(1);
    end
  end

`ifdef MAP_SEL_TOUT_EN
  localparam int TW = $clog2(TOUT_CYC) + 1;
  localparam logic [TW-1:0] TOUT_TC = TW'(TOUT_CYC - 1);

  logic [TW-1:0] tout_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tout_cnt <= '0;
      err      <= 1'b0;
    end else begin
      if (state != QUIET) begin
        tout_cnt <= '0;
      end else if (tout_cnt != TOUT_TC) begin
        tout_cnt <= tout_cnt + TW'(1);
      end
      if (tout_hit && (quiet_cnt != QUIET_FULL)) begin
        err <= 1'b1;
      end
    end
  end

  assign tout_hit = (state == QUIET) && (tout_cnt == TOUT_TC);
`else
  localparam int tout_unused = TOUT_CYC;

  assign tout_hit = 1'b0;
  assign err      = 1'b0;
`endif

  always_comb begin
    next_state = state;
    latch_req  = 1'b0;
    load_idx   = 1'b0;
    exit_rel   = 1'b0;
    map_rst    = 1'b0;
    bus_blank  = 1'b0;
    busy       = 1'b1;
    case (state)
      INIT: begin
        map_rst   = 1'b1;
        bus_blank = 1'b1;
        if (hold_cnt == HOLD_TC) next_state = REL;
      end
      IDLE: begin
        busy = 1'b0;
        if (req) begin
          latch_req  = 1'b1;
          next_state = QUIET;
        end
      end
      QUIET: begin
        if (quiet_cnt == QUIET_FULL || tout_hit) next_state = BLANK;
      end
      BLANK: begin
        map_rst   = 1'b1;
        bus_blank = 1'b1;
        if (hold_cnt == HOLD_TC) begin
          load_idx   = 1'b1;
          next_state = REL;
        end
      end
      REL: begin
        bus_blank = 1'b1;
        if (m2_rise || hold_cnt == REL_TC) begin
          exit_rel   = 1'b1;
          next_state = IDLE;
        end
      end
      default: next_state = INIT;
    endcase
  end

  // hold_cnt restarts on every state change, so it times INIT, BLANK and REL alike.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= INIT;
      hold_cnt  <= '0;
      pend_idx  <= '0;
      map_idx   <= RST_VAL;
      from_init <= 1'b1;
      ack       <= 1'b0;
    end else begin
      state <= next_state;
      if (next_state != state) begin
        hold_cnt <= '0;
      end else if (state == INIT || state == BLANK || state == REL) begin
        hold_cnt <= hold_cnt + HW'(1);
      end else begin
        hold_cnt <= '0;
      end
      if (latch_req) pend_idx <= req_idx;
      if (load_idx)  map_idx  <= pend_idx;
      if (exit_rel)  from_init <= 1'b0;
      ack <= exit_rel & ~from_init;
    end
  end

endmodule

// File: tb/tb_map_sel_ctrl.sv
// Bench for map_sel_ctrl: expected timelines are derived from the recorded M2 history by plain arithmetic.
// Define MAP_SEL_TOUT_EN to also exercise the quiet-window timeout.
module tb_map_sel_ctrl;

  localparam int IDX_W    = 8;
  localparam int RST_IDX  = 0;
  localparam int IDLE_CYC = 4;
  localparam int HOLD_CYC = 16;
  localparam int TOUT_CYC = 4096;
  localparam int MAXC     = 16384;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             cpu_m2 = 1'b0;
  logic             req = 1'b0;
  logic [IDX_W-1:0] req_idx = '0;
  logic [IDX_W-1:0] map_idx;
  logic             map_rst;
  logic             bus_blank;
  logic             busy;
  logic             ack;
  logic             err;

  int               checks = 0;
  int               errors = 0;
  int               cyc = 0;
  logic             m2_at [MAXC];
  logic [IDX_W-1:0] cur_idx = IDX_W'(RST_IDX);
  logic             err_exp = 1'b0;

  map_sel_ctrl #(
    .IDX_W(IDX_W), .RST_IDX(RST_IDX), .IDLE_CYC(IDLE_CYC),
    .HOLD_CYC(HOLD_CYC), .TOUT_CYC(TOUT_CYC)
  ) dut (
    .clk(clk), .rst(rst), .cpu_m2(cpu_m2), .req(req), .req_idx(req_idx),
    .map_idx(map_idx), .map_rst(map_rst), .bus_blank(bus_blank),
    .busy(busy), .ack(ack), .err(err)
  );

  always #5 clk = ~clk;

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s at cycle %0d: observed %0h expected %0h", tag, cyc, obs, exp);
    end
  endtask

  task automatic check_all(input logic [IDX_W-1:0] e_idx, input logic e_rst, input logic e_blank,
                           input logic e_busy, input logic e_ack);
    check_output("map_idx", 32'(map_idx), 32'(e_idx));
    check_output("map_rst", 32'(map_rst), 32'(e_rst));
    check_output("bus_blank", 32'(bus_blank), 32'(e_blank));
    check_output("busy", 32'(busy), 32'(e_busy));
    check_output("ack", 32'(ack), 32'(e_ack));
    check_output("err", 32'(err), 32'(err_exp));
  endtask

  // Synchronized M2 as seen by the block after clock edge n.
  function automatic logic s2(input int n);
    if (n < 1 || n > MAXC) return 1'b0;
    return m2_at[n-1];
  endfunction

  // Length of the current run of synchronized lows after edge n, capped at IDLE_CYC.
  function automatic int q_at(input int n);
    int c = 0;
    for (int j = n - 1; j >= 0; j--) begin
      if (c == IDLE_CYC || s2(j)) break;
      c++;
    end
    return c;
  endfunction

  // Edge after which the block is back in IDLE, given the release phase starts after edge rs.
  function automatic int rel_exit(input int rs);
    for (int k = rs; k < rs + IDLE_CYC - 1; k++) begin
      if (s2(k) && !s2(k - 1)) return k + 1;
    end
    return rs + IDLE_CYC;
  endfunction

  task automatic fill_m2(input int from, input int len, input int mode, input int per);
    for (int i = 0; i < len + 64; i++) begin
      if (from + i < MAXC) begin
        if (i >= len)       m2_at[from + i] = 1'b0;
        else if (mode == 1) m2_at[from + i] = ((i % per) == 0);
        else if (mode == 2) m2_at[from + i] = 1'($urandom_range(0, 1));
        else                m2_at[from + i] = 1'b0;
      end
    end
  endtask

  task automatic apply_stimulus(input logic rq, input logic [IDX_W-1:0] ri);
    if (cyc + 1 >= MAXC) begin
      $display("[TB] FAIL cycle_budget: observed %0d required below %0d", cyc + 1, MAXC);
      $fatal(1, "[TB] cycle budget exhausted");
    end
    cpu_m2  = m2_at[cyc + 1];
    req     = rq;
    req_idx = ri;
    @(posedge clk);
    cyc++;
    #1;
  endtask

  task automatic do_reset(input int mode);
    int x;
    #2 rst = 1'b1;
    err_exp = 1'b0;
    cur_idx = IDX_W'(RST_IDX);
    #1;
    check_all(cur_idx, 1'b1, 1'b1, 1'b1, 1'b0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    cyc = 0;
    m2_at[0] = 1'b0;
    fill_m2(1, 24, mode, 1);
    x = rel_exit(HOLD_CYC);
    for (int k = 1; k <= x + 1; k++) begin
      apply_stimulus(k == 1, IDX_W'($urandom));
      check_all(cur_idx, k < HOLD_CYC, k < x, k < x, 1'b0);
    end
  endtask

  task automatic do_request(input logic [IDX_W-1:0] idx, input int mode, input int per, input int len,
                            input int extra_off, input logic [IDX_W-1:0] extra_idx, input int abort_off);
    int   r, bn, b, rr, x;
    logic timed;
    r = cyc + 1;
    fill_m2(r, len, mode, per);
    bn = -1;
    for (int n = r; n < r + len + 40; n++) begin
      if (q_at(n) == IDLE_CYC) begin
        bn = n;
        break;
      end
    end
    if (bn < 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL quiet_window: observed none required one before cycle %0d", r + len + 40);
      return;
    end
    timed = 1'b0;
    b = bn + 1;
`ifdef MAP_SEL_TOUT_EN
    if (bn - r >= TOUT_CYC) begin
      b = r + TOUT_CYC;
      timed = 1'b1;
    end
`endif
    rr = b + HOLD_CYC;
    x  = rel_exit(rr);
    for (int k = r; k <= x + 1; k++) begin
      if (abort_off >= 0 && k == b + abort_off) return;
      if (k == r)
        apply_stimulus(1'b1, idx);
      else if (extra_off >= 0 && k == b + extra_off)
        apply_stimulus(1'b1, extra_idx);
      else
        apply_stimulus(1'b0, IDX_W'($urandom));
      if (timed && k >= b) err_exp = 1'b1;
      check_all((k >= rr) ? idx : cur_idx, (k >= b) && (k < rr), (k >= b) && (k < x), k < x, k == x);
    end
    cur_idx = idx;
  endtask

  task automatic idle_gap(input int n);
    for (int i = 0; i < n; i++) begin
      if (cyc + 1 < MAXC) m2_at[cyc + 1] = 1'($urandom_range(0, 1));
      apply_stimulus(1'b0, IDX_W'($urandom));
      check_all(cur_idx, 1'b0, 1'b0, 1'b0, 1'b0);
    end
  endtask

  initial begin
    do_reset(0);
    do_request(8'd74, 0, 1, 0, -1, 8'd0, -1);
    idle_gap(3);
    do_request(8'd12, 1, 3, 30, -1, 8'd0, -1);
    idle_gap(2);
    do_request(8'd118, 0, 1, 0, 5, 8'd205, -1);
    do_request(8'd64, 0, 1, 0, -1, 8'd0, 5);
    do_reset(2);
    idle_gap(4);
    for (int i = 0; i < 10; i++) begin
      do_request(IDX_W'($urandom), 2, 1, $urandom_range(0, 30),
                 ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, HOLD_CYC)) : -1,
                 IDX_W'($urandom), -1);
      idle_gap($urandom_range(0, 5));
    end
`ifdef MAP_SEL_TOUT_EN
    idle_gap(1);
    do_request(8'd47, 1, 2, 4300, -1, 8'd0, -1);
    idle_gap(3);
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
